fetch_ctrl: RTL and testbench



---
 rtl/fetch_ctrl_if.sv | 25 ++
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and
// the SRAM-like instruction port. One outstanding request at a time.
interface fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns pcF, issues one instruction request at a time,
// buffers the returned word toward Decode, and applies decode stalls,
// delay-slot branch redirects and exception flushes.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallD,
    input  logic               br_redirect,
    input  logic [31:0]        br_target,
    input  logic               exc_flush,
    input  logic [31:0]        exc_pc,
    fetch_ctrl_if.master       bus,
    output logic [31:0]        pcF,
    output logic [31:0]        instD,
    output logic [31:0]        pcD,
    output logic               instD_valid
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } state_t;

    state_t      state, state_n;
    logic [31:0] pcF_n, instD_n, pcD_n;
    logic        valid_n;
    logic        pend, pend_n;
    logic [31:0] pend_tgt, pend_tgt_n;
    logic        req, accept;

    // Request issue: only when the buffer is empty or drains this cycle.
    always_comb begin
        req    = (state == REQ) && (!instD_valid || !stallD);
        accept = req && bus.inst_addr_ok;
    end

    assign bus.inst_req  = req;
    assign bus.inst_addr = pcF;

    // Next-state and datapath updates; exception flush overrides everything.
    always_comb begin
        state_n    = state;
        pcF_n      = pcF;
        instD_n    = instD;
        pcD_n      = pcD;
        valid_n    = instD_valid && stallD;
        pend_n     = pend;
        pend_tgt_n = pend_tgt;

        if (exc_flush) begin
            pcF_n   = exc_pc;
            valid_n = 1'b0;
            pend_n  = 1'b0;
            unique case (state)
                IDLE:    state_n = REQ;
                REQ:     state_n = accept ? DISCARD : REQ;
                WAIT:    state_n = bus.inst_data_ok ? REQ : DISCARD;
                DISCARD: state_n = bus.inst_data_ok ? REQ : DISCARD;
                default: state_n = IDLE;
            endcase
        end else begin
            if (br_redirect) begin
                pend_n     = 1'b1;
                pend_tgt_n = br_target;
            end
            unique case (state)
                IDLE: state_n = REQ;
                REQ: begin
                    if (accept) state_n = WAIT;
                end
                WAIT: begin
                    if (bus.inst_data_ok) begin
                        instD_n = bus.inst_rdata;
                        pcD_n   = pcF;
                        valid_n = 1'b1;
                        // A redirect arriving with the delay-slot response
                        // applies directly instead of being parked.
                        if (br_redirect) begin
                            pcF_n  = br_target;
                            pend_n = 1'b0;
                        end else if (pend) begin
                            pcF_n  = pend_tgt;
                            pend_n = 1'b0;
                        end else begin
                            pcF_n  = pcF + PC_STEP;
                        end
                        state_n = REQ;
                    end
                end
                DISCARD: begin
                    if (bus.inst_data_ok) state_n = REQ;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pcF         <= RESET_PC;
            instD       <= '0;
            pcD         <= '0;
            instD_valid <= 1'b0;
            pend        <= 1'b0;
            pend_tgt    <= '0;
        end else begin
            state       <= state_n;
            pcF         <= pcF_n;
            instD       <= instD_n;
            pcD         <= pcD_n;
            instD_valid <= valid_n;
            pend        <= pend_n;
            pend_tgt    <= pend_tgt_n;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, decode stall, delay-slot
// branch, exception flushes, async reset and PC wrap.
module tb_fetch_ctrl;
    logic        clk;
    logic        rst;
    logic        stallD;
    logic        br_redirect;
    logic [31:0] br_target;
    logic        exc_flush;
    logic [31:0] exc_pc;
    logic [31:0] pcF, instD, pcD;
    logic        instD_valid;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .RESET_PC(32'hBFC0_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stallD     (stallD),
        .br_redirect(br_redirect),
        .br_target  (br_target),
        .exc_flush  (exc_flush),
        .exc_pc     (exc_pc),
        .bus        (bus),
        .pcF        (pcF),
        .instD      (instD),
        .pcD        (pcD),
        .instD_valid(instD_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Normal fetch from REQ: addr_ok now, data_ok lat cycles after acceptance.
    task automatic fetch(input logic [31:0] a, input int lat);
        logic [31:0] nxt;
        nxt = a + 32'd4;
        #1;
        n_checks++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL fetch_req got %b want 1 @%h", bus.inst_req, a); end
        n_checks++; if (bus.inst_addr !== a) begin n_fail++; $display("FAIL fetch_addr got %h want %h", bus.inst_addr, a); end
        bus.inst_addr_ok = 1'b1;
        cyc();
        bus.inst_addr_ok = 1'b0;
        #1;
        n_checks++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL fetch_wait_req got %b want 0 @%h", bus.inst_req, a); end
        repeat (lat) cyc();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = mem(a);
        cyc();
        bus.inst_data_ok = 1'b0;
        #1;
        n_checks++; if (instD_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid got %b want 1 @%h", instD_valid, a); end
        n_checks++; if (instD !== mem(a)) begin n_fail++; $display("FAIL fetch_instD got %h want %h", instD, mem(a)); end
        n_checks++; if (pcD !== a) begin n_fail++; $display("FAIL fetch_pcD got %h want %h", pcD, a); end
        n_checks++; if (pcF !== nxt) begin n_fail++; $display("FAIL fetch_pcF got %h want %h", pcF, nxt); end
    endtask

    task automatic test_reset();
        rst = 1'b1; stallD = 1'b0; br_redirect = 1'b0; br_target = '0;
        exc_flush = 1'b0; exc_pc = '0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
        repeat (2) cyc();
        n_checks++; if (pcF !== 32'hBFC0_0000) begin n_fail++; $display("FAIL reset_pcF got %h want bfc00000", pcF); end
        n_checks++; if (instD !== 32'h0) begin n_fail++; $display("FAIL reset_instD got %h want 0", instD); end
        n_checks++; if (pcD !== 32'h0) begin n_fail++; $display("FAIL reset_pcD got %h want 0", pcD); end
        n_checks++; if (instD_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instD_valid); end
        n_checks++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus.inst_req); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b want 0", bus.inst_req); end
        cyc();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            fetch(32'hBFC0_0000 + 32'(4 * i), 0);
        end
    endtask

    task automatic test_stall();
        stallD = 1'b1;
        #1;
        n_checks++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL stall_req0 got %b want 0", bus.inst_req); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL stall_req got %b want 0 cyc %0d", bus.inst_req, i); end
            n_checks++; if (instD_valid !== 1'b1 || instD !== mem(32'hBFC0_0008) || pcD !== 32'hBFC0_0008) begin
                n_fail++; $display("FAIL stall_hold got v=%b %h/%h want v=1 %h/bfc00008", instD_valid, instD, pcD, mem(32'hBFC0_0008));
            end
        end
        stallD = 1'b0;
        fetch(32'hBFC0_000C, 2);
    endtask

    task automatic test_branch();
        #1;
        n_checks++; if (bus.inst_addr !== 32'hBFC0_0010) begin n_fail++; $display("FAIL br_slot_addr got %h want bfc00010", bus.inst_addr); end
        bus.inst_addr_ok = 1'b1;
        cyc();
        bus.inst_addr_ok = 1'b0;
        br_redirect = 1'b1; br_target = 32'h8000_1000;
        cyc();
        br_redirect = 1'b0; br_target = '0;
        #1;
        n_checks++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL br_wait_req got %b want 0", bus.inst_req); end
        bus.inst_data_ok = 1'b1; bus.inst_rdata = mem(32'hBFC0_0010);
        cyc();
        bus.inst_data_ok = 1'b0;
        #1;
        n_checks++; if (pcD !== 32'hBFC0_0010 || instD !== mem(32'hBFC0_0010)) begin n_fail++; $display("FAIL br_slot_data got %h/%h want bfc00010/%h", pcD, instD, mem(32'hBFC0_0010)); end
        n_checks++; if (bus.inst_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL br_target_addr got %h want 80001000", bus.inst_addr); end
        // Redirect arriving together with the response of the slot.
        bus.inst_addr_ok = 1'b1;
        cyc();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1; bus.inst_rdata = mem(32'h8000_1000);
        br_redirect = 1'b1; br_target = 32'h8000_2000;
        cyc();
        bus.inst_data_ok = 1'b0; br_redirect = 1'b0;
        #1;
        n_checks++; if (pcF !== 32'h8000_2000) begin n_fail++; $display("FAIL br_direct_pcF got %h want 80002000", pcF); end
        n_checks++; if (pcD !== 32'h8000_1000) begin n_fail++; $display("FAIL br_direct_pcD got %h want 80001000", pcD); end
    endtask

    task automatic test_exc_wait();
        bus.inst_addr_ok = 1'b1;
        cyc();
        bus.inst_addr_ok = 1'b0;
        exc_flush = 1'b1; exc_pc = 32'hBFC0_0380;
        cyc();
        exc_flush = 1'b0; exc_pc = '0;
        #1;
        n_checks++; if (bus.inst_req !== 1'b0 || pcF !== 32'hBFC0_0380) begin n_fail++; $display("FAIL exc_discard got req=%b pcF=%h want 0/bfc00380", bus.inst_req, pcF); end
        repeat (2) cyc();
        bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hDEAD_BEEF;
        cyc();
        bus.inst_data_ok = 1'b0;
        #1;
        n_checks++; if (instD_valid !== 1'b0) begin n_fail++; $display("FAIL exc_drop_valid got %b want 0", instD_valid); end
        n_checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0380) begin n_fail++; $display("FAIL exc_next got req=%b addr=%h want 1/bfc00380", bus.inst_req, bus.inst_addr); end
    endtask

    task automatic test_exc_branch_same();
        fetch(32'hBFC0_0380, 0);
        bus.inst_addr_ok = 1'b1;
        exc_flush = 1'b1; exc_pc = 32'hBFC0_0380;
        br_redirect = 1'b1; br_target = 32'h8000_3000;
        cyc();
        bus.inst_addr_ok = 1'b0; exc_flush = 1'b0; br_redirect = 1'b0;
        #1;
        n_checks++; if (bus.inst_req !== 1'b0 || pcF !== 32'hBFC0_0380 || instD_valid !== 1'b0) begin
            n_fail++; $display("FAIL excbr_discard got req=%b pcF=%h v=%b want 0/bfc00380/0", bus.inst_req, pcF, instD_valid);
        end
        bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h1111_2222;
        cyc();
        bus.inst_data_ok = 1'b0;
        #1;
        n_checks++; if (instD_valid !== 1'b0) begin n_fail++; $display("FAIL excbr_drop_valid got %b want 0", instD_valid); end
        fetch(32'hBFC0_0380, 1);
    endtask

    task automatic test_async_rst();
        bus.inst_addr_ok = 1'b1;
        cyc();
        bus.inst_addr_ok = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (pcF !== 32'hBFC0_0000 || instD !== 32'h0 || pcD !== 32'h0 || instD_valid !== 1'b0 || bus.inst_req !== 1'b0) begin
            n_fail++; $display("FAIL arst_values got pcF=%h instD=%h pcD=%h v=%b req=%b", pcF, instD, pcD, instD_valid, bus.inst_req);
        end
        cyc();
        rst = 1'b0;
        bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h3333_4444;
        #1;
        n_checks++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL arst_idle_req got %b want 0", bus.inst_req); end
        cyc();
        bus.inst_data_ok = 1'b0;
        #1;
        n_checks++; if (instD_valid !== 1'b0 || bus.inst_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL arst_stray got v=%b addr=%h want 0/bfc00000", instD_valid, bus.inst_addr); end
        fetch(32'hBFC0_0000, 0);
    endtask

    task automatic test_wrap();
        exc_flush = 1'b1; exc_pc = 32'hFFFF_FFFC;
        cyc();
        exc_flush = 1'b0;
        fetch(32'hFFFF_FFFC, 0);
        n_checks++; if (pcF !== 32'h0) begin n_fail++; $display("FAIL wrap_pcF got %h want 0", pcF); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_exc_wait();
        test_exc_branch_same();
        test_async_rst();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
